// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side controller for the UART RX FIFO. It turns CPU reads of the
//   receive buffer into FIFO pops and flushes the FIFO on a clear request. It
//   also builds the line-status byte and the three receive interrupt sources:
//   data available, character timeout and line status.
//
//   Optional feature: define UART_RX_CHAR_TIMEOUT_EN to build the character
//   timeout counter. When it is not defined, char_to_irq is tied low.
//
// Ports
//   PCLK, PRESETn    clock; asynchronous active-low reset
//   enable           16x baud tick, one PCLK wide
//   LCR[7:0]         line control: [1:0] word length, [2] stop bits, [3] parity
//   FCR_trig[1:0]    RX trigger level select (1/4/8/14 entries)
//   fifo_clear       pulse: flush the RX FIFO
//   rbr_read         pulse: CPU read of RBR
//   lsr_read         pulse: CPU read of LSR
//   rx_fifo_out      FIFO head: [10] break, [9] parity err, [8] framing err,
//                    [7:0] data
//   rx_fifo_count    FIFO occupancy
//   rx_fifo_empty    FIFO empty
//   push_rx_fifo     RX engine push strobe
//   rx_overrun       overrun flag, valid in the push cycle
//   push_err         OR of the error flags of the entry being pushed
//   pop_rx_fifo      FIFO pop strobe
//   rbr_data         received data masked to the word length
//   lsr              line status {errFIFO, 0, 0, BI, FE, PE, OE, DR}
//   rx_avail_irq     occupancy at or above the trigger level
//   char_to_irq      character timeout
//   rx_ls_irq        line-status interrupt
//   ctrl_busy        high while a pop or a drain is in progress
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int TO_CHARS   = 4,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             enable,
   input  logic [7:0]       LCR,
   input  logic [1:0]       FCR_trig,
   input  logic             fifo_clear,
   input  logic             rbr_read,
   input  logic             lsr_read,
   input  logic [10:0]      rx_fifo_out,
   input  logic [CNT_W-1:0] rx_fifo_count,
   input  logic             rx_fifo_empty,
   input  logic             push_rx_fifo,
   input  logic             rx_overrun,
   input  logic             push_err,
   output logic             pop_rx_fifo,
   output logic [7:0]       rbr_data,
   output logic [7:0]       lsr,
   output logic             rx_avail_irq,
   output logic             char_to_irq,
   output logic             rx_ls_irq,
   output logic             ctrl_busy
);

   localparam logic [CNT_W-1:0] ERR_MAX = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_DRAIN} state_t;

   state_t           r_state;
   logic             r_oe;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_pop;
   logic             w_err_inc;
   logic             w_err_dec;
   logic [1:0]       w_shift;
   logic [7:0]       w_mask;
   logic             w_pe;
   logic             w_fe;
   logic             w_bi;
   logic [7:0]       w_lsr;

   // Trigger level from the FCR select code
   function automatic logic [CNT_W-1:0] f_trig(input logic [1:0] sel);
      case (sel)
         2'b00:   f_trig = CNT_W'(1);
         2'b01:   f_trig = CNT_W'(4);
         2'b10:   f_trig = CNT_W'(8);
         default: f_trig = CNT_W'(14);
      endcase
   endfunction

   // Saturating up/down step of the error-in-FIFO count; simultaneous up and
   // down cancel out
   function automatic logic [CNT_W-1:0] f_err_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic dec);
      f_err_next = cnt;
      if (inc && !dec && cnt != ERR_MAX)
         f_err_next = cnt + 1'b1;
      else if (dec && !inc && cnt != '0)
         f_err_next = cnt - 1'b1;
   endfunction

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (fifo_clear)
                  r_state <= S_DRAIN;
               else if (rbr_read && !rx_fifo_empty)
                  r_state <= S_POP;
            end
            // A read arriving here is dropped; the bus cannot issue a new
            // read this soon after the previous one
            S_POP:   r_state <= S_IDLE;
            S_DRAIN: if (rx_fifo_empty) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Draining pops every cycle the FIFO has data, including late pushes
   assign w_pop       = (r_state == S_POP) || ((r_state == S_DRAIN) && !rx_fifo_empty);
   assign pop_rx_fifo = w_pop;
   assign ctrl_busy   = (r_state != S_IDLE);

   // Word length 5..8 bits selects how many low data bits are kept
   assign w_shift  = 2'd3 - LCR[1:0];
   assign w_mask   = 8'hFF >> w_shift;
   assign rbr_data = rx_fifo_empty ? 8'h00 : (rx_fifo_out[7:0] & w_mask);

   // Overrun is sticky; a new overrun beats a clearing LSR read
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_oe <= 1'b0;
      else if (push_rx_fifo && rx_overrun)
         r_oe <= 1'b1;
      else if (lsr_read)
         r_oe <= 1'b0;
   end

   assign w_err_inc = push_rx_fifo & push_err;
   assign w_err_dec = w_pop & (|rx_fifo_out[10:8]);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_err_cnt <= '0;
      else if ((r_state == S_IDLE) && fifo_clear)
         r_err_cnt <= '0;
      else
         r_err_cnt <= f_err_next(r_err_cnt, w_err_inc, w_err_dec);
   end

   assign w_pe  = !rx_fifo_empty & rx_fifo_out[9];
   assign w_fe  = !rx_fifo_empty & rx_fifo_out[8];
   assign w_bi  = !rx_fifo_empty & rx_fifo_out[10];
   assign w_lsr = {(r_err_cnt != '0), 2'b00, w_bi, w_fe, w_pe, r_oe, !rx_fifo_empty};

   // Status and interrupt outputs read as zero while reset is held, even if
   // the FIFO still reports contents
   assign lsr          = PRESETn ? w_lsr : 8'h00;
   assign rx_ls_irq    = PRESETn & (r_oe | w_pe | w_fe | w_bi);
   assign rx_avail_irq = PRESETn & (rx_fifo_count >= f_trig(FCR_trig));

`ifdef UART_RX_CHAR_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CHARS * 16 * 12 + 1);

   logic [3:0]      w_bits;
   logic [TO_W-1:0] w_thr;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_char_to;
   logic            w_to_clr;
   logic            w_to_inc;
   logic            w_unused;

   // Character length: start + data + parity + stop bits
   assign w_bits   = 4'd6 + {2'b00, LCR[1:0]} + {3'b000, LCR[3]} + (LCR[2] ? 4'd2 : 4'd1);
   assign w_thr    = TO_W'(TO_CHARS * 16 * int'(w_bits));
   assign w_to_clr = push_rx_fifo | w_pop | rx_fifo_empty;
   assign w_to_inc = enable & (r_state == S_IDLE) & (r_to_cnt < w_thr);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_to_cnt  <= '0;
         r_char_to <= 1'b0;
      end else begin
         if (w_to_clr)
            r_to_cnt <= '0;
         else if (w_to_inc)
            r_to_cnt <= r_to_cnt + 1'b1;

         // Raise on the tick that reaches the threshold; the >= term keeps
         // it raised if LCR shrinks the threshold below a held count
         if (push_rx_fifo || w_pop || (r_state == S_DRAIN))
            r_char_to <= 1'b0;
         else if (!rx_fifo_empty &&
                  ((w_to_inc && (r_to_cnt == w_thr - 1'b1)) || (r_to_cnt >= w_thr)))
            r_char_to <= 1'b1;
      end
   end

   assign char_to_irq = r_char_to;
   assign w_unused    = ^LCR[7:4];
`else
   logic w_unused;

   assign char_to_irq = 1'b0;
   assign w_unused    = ^{LCR[7:2], enable};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

`ifdef UART_RX_CHAR_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        enable;
   logic [7:0]  LCR;
   logic [1:0]  FCR_trig;
   logic        fifo_clear;
   logic        rbr_read;
   logic        lsr_read;
   logic [10:0] rx_fifo_out;
   logic [4:0]  rx_fifo_count;
   logic        rx_fifo_empty;
   logic        push_rx_fifo;
   logic        rx_overrun;
   logic        push_err;
   logic        pop_rx_fifo;
   logic [7:0]  rbr_data;
   logic [7:0]  lsr;
   logic        rx_avail_irq;
   logic        char_to_irq;
   logic        rx_ls_irq;
   logic        ctrl_busy;

   uart_rx_ctrl #(.FIFO_DEPTH(16), .TO_CHARS(4)) u_dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .enable        (enable),
      .LCR           (LCR),
      .FCR_trig      (FCR_trig),
      .fifo_clear    (fifo_clear),
      .rbr_read      (rbr_read),
      .lsr_read      (lsr_read),
      .rx_fifo_out   (rx_fifo_out),
      .rx_fifo_count (rx_fifo_count),
      .rx_fifo_empty (rx_fifo_empty),
      .push_rx_fifo  (push_rx_fifo),
      .rx_overrun    (rx_overrun),
      .push_err      (push_err),
      .pop_rx_fifo   (pop_rx_fifo),
      .rbr_data      (rbr_data),
      .lsr           (lsr),
      .rx_avail_irq  (rx_avail_irq),
      .char_to_irq   (char_to_irq),
      .rx_ls_irq     (rx_ls_irq),
      .ctrl_busy     (ctrl_busy)
   );

   always #5 PCLK = ~PCLK;

   // Reference state: FIFO contents, sticky overrun, and whether a pop or a
   // flush is outstanding at transaction level
   logic [10:0] q[$];
   logic        m_oe;
   logic        m_pend;
   logic        m_drain;
   logic [10:0] push_ent;
   logic [10:0] e_r;
   int          n_chk;
   int          n_pass;
   int          pop_cnt;
   int          early;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int trig_lvl(input logic [1:0] sel);
      int tl[4] = '{1, 4, 8, 14};
      return tl[sel];
   endfunction

   function automatic logic [7:0] exp_rbr();
      int m;
      logic [7:0] d;
      if (q.size() == 0) return 8'h00;
      m = (1 << (5 + int'(LCR[1:0]))) - 1;
      d = q[0][7:0];
      return d & m[7:0];
   endfunction

   // Error-in-FIFO is "some error entry is still queued", except that a flush
   // forgets everything already queued
   function automatic logic [7:0] exp_lsr();
      logic [7:0] r;
      logic       any;
      logic [10:0] h;
      r = 8'h00;
      any = 1'b0;
      foreach (q[i]) begin
         h = q[i];
         if (|h[10:8]) any = 1'b1;
      end
      if (m_drain) any = 1'b0;
      r[0] = (q.size() != 0);
      r[1] = m_oe;
      if (q.size() != 0) begin
         h = q[0];
         r[2] = h[9];
         r[3] = h[8];
         r[4] = h[10];
      end
      r[7] = any;
      return r;
   endfunction

   task automatic drive_fifo();
      rx_fifo_count = 5'(q.size());
      rx_fifo_empty = (q.size() == 0);
      rx_fifo_out   = (q.size() == 0) ? 11'h7FF : q[0];
   endtask

   task automatic step();
      logic       exp_pop;
      logic       busy;
      logic       np;
      logic       nd;
      logic [7:0] el;
      @(negedge PCLK);
      exp_pop = m_pend | (m_drain && (q.size() != 0));
      busy    = m_pend | m_drain;
      el      = exp_lsr();
      chk("pop", pop_rx_fifo, exp_pop);
      chk("busy", ctrl_busy, busy);
      chk("rbr", rbr_data, exp_rbr());
      chk("lsr", lsr, el);
      chk("avail", rx_avail_irq, q.size() >= trig_lvl(FCR_trig));
      chk("ls_irq", rx_ls_irq, |el[4:1]);
      if (pop_rx_fifo) pop_cnt++;
      np = !busy && !fifo_clear && rbr_read && (q.size() != 0);
      nd = m_drain ? (q.size() != 0) : (!busy && fifo_clear);
      if (push_rx_fifo && rx_overrun) m_oe = 1'b1;
      else if (lsr_read) m_oe = 1'b0;
      if (pop_rx_fifo && q.size() != 0) void'(q.pop_front());
      if (push_rx_fifo) q.push_back(push_ent);
      m_pend  = np;
      m_drain = nd;
      @(posedge PCLK);
      #1;
      drive_fifo();
      rbr_read     = 1'b0;
      fifo_clear   = 1'b0;
      lsr_read     = 1'b0;
      push_rx_fifo = 1'b0;
      push_err     = 1'b0;
      rx_overrun   = 1'b0;
      enable       = 1'b0;
      #1;
   endtask

   task automatic do_push(input logic [10:0] e, input logic ovr);
      push_ent     = e;
      push_rx_fifo = 1'b1;
      push_err     = |e[10:8];
      rx_overrun   = ovr;
      step();
   endtask

   task automatic read_one();
      rbr_read = 1'b1;
      step();
      step();
   endtask

   task automatic drain_all();
      fifo_clear = 1'b1;
      step();
      for (int i = 0; i < 40 && m_drain; i++) step();
      chk("drain_idle", ctrl_busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_pass = 0; pop_cnt = 0; early = 0;
      m_oe = 0; m_pend = 0; m_drain = 0;
      PRESETn = 1'b0; enable = 0; LCR = 8'h03; FCR_trig = 2'b00;
      fifo_clear = 0; rbr_read = 0; lsr_read = 0;
      push_rx_fifo = 0; rx_overrun = 0; push_err = 0; push_ent = '0;
      q = '{11'h0A5, 11'h03C, 11'h0F0};
      drive_fifo();

      // Reset held with three entries queued
      #12;
      chk("rst_pop", pop_rx_fifo, 1'b0);
      chk("rst_busy", ctrl_busy, 1'b0);
      chk("rst_lsr", lsr, 8'h00);
      chk("rst_avail", rx_avail_irq, 1'b0);
      chk("rst_lsirq", rx_ls_irq, 1'b0);
      chk("rst_cto", char_to_irq, 1'b0);
      chk("rst_rbr", rbr_data, 8'hA5);
      @(posedge PCLK);
      #1 PRESETn = 1'b1;

      // Single read: data in the read cycle, one pop the next cycle
      rbr_read = 1'b1;
      #1;
      chk("rbr_head", rbr_data, 8'hA5);
      step();
      chk("pop_next", pop_rx_fifo, 1'b1);
      chk("busy_pop", ctrl_busy, 1'b1);
      step();
      chk("pop_once", pop_rx_fifo, 1'b0);
      chk("busy_once", ctrl_busy, 1'b0);
      read_one();
      read_one();
      rbr_read = 1'b1;
      #1;
      chk("rbr_empty", rbr_data, 8'h00);
      step();
      chk("pop_empty", pop_rx_fifo, 1'b0);

      // 5-bit word length
      LCR = 8'h00;
      do_push(11'h0FF, 1'b0);
      rbr_read = 1'b1;
      #1;
      chk("rbr_5bit", rbr_data, 8'h1F);
      step();
      step();
      LCR = 8'h03;

      // Trigger level 8
      FCR_trig = 2'b10;
      for (int i = 0; i < 7; i++) do_push({3'b000, 8'($urandom)}, 1'b0);
      chk("avail_7", rx_avail_irq, 1'b0);
      do_push({3'b000, 8'($urandom)}, 1'b0);
      chk("avail_8", rx_avail_irq, 1'b1);
      read_one();
      chk("avail_pop", rx_avail_irq, 1'b0);
      FCR_trig = 2'b00;

      // Sticky overrun
      do_push({3'b000, 8'h11}, 1'b1);
      chk("oe_set", lsr[1], 1'b1);
      chk("oe_lsirq", rx_ls_irq, 1'b1);
      lsr_read = 1'b1;
      step();
      chk("oe_clr", lsr[1], 1'b0);
      lsr_read = 1'b1;
      do_push({3'b000, 8'h22}, 1'b1);
      chk("oe_win", lsr[1], 1'b1);
      lsr_read = 1'b1;
      step();

      // Error-in-FIFO and flush
      drain_all();
      do_push(11'h255, 1'b0);
      do_push(11'h166, 1'b0);
      do_push(11'h077, 1'b0);
      chk("errfifo", lsr[7], 1'b1);
      pop_cnt = 0;
      drain_all();
      chk("drain_pops", pop_cnt, 3);
      chk("drain_err", lsr[7], 1'b0);
      chk("drain_dr", lsr[0], 1'b0);

      // Reset while the pop strobe is high
      do_push(11'h05A, 1'b0);
      rbr_read = 1'b1;
      step();
      chk("pre_rst_pop", pop_rx_fifo, 1'b1);
      PRESETn = 1'b0;
      #1;
      chk("rst_mid_pop", pop_rx_fifo, 1'b0);
      chk("rst_mid_busy", ctrl_busy, 1'b0);
      m_pend = 1'b0; m_drain = 1'b0; m_oe = 1'b0;
      #1 PRESETn = 1'b1;
      step();

      // Random traffic
      for (int it = 0; it < 300; it++) begin
         LCR        = 8'($urandom_range(0, 15));
         FCR_trig   = 2'($urandom_range(0, 3));
         fifo_clear = !(m_pend || m_drain) && ($urandom_range(0, 49) == 0);
         rbr_read   = ($urandom_range(0, 9) < 3);
         lsr_read   = ($urandom_range(0, 9) == 0);
         rx_overrun = ($urandom_range(0, 9) == 0);
         if (q.size() < 16 && $urandom_range(0, 9) < 4) begin
            e_r = 11'($urandom);
            if (fifo_clear || m_drain || $urandom_range(0, 2) != 0) e_r[10:8] = 3'b000;
            push_ent     = e_r;
            push_err     = |e_r[10:8];
            push_rx_fifo = 1'b1;
         end
         step();
      end

      // Character timeout: 10-bit characters, one entry, idle line
      LCR = 8'h03;
      FCR_trig = 2'b00;
      drain_all();
      do_push(11'h0C3, 1'b0);
      for (int t = 1; t <= 645; t++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step();
         enable = 1'b1;
         step();
         if (t < 640 && char_to_irq) early++;
         if (t == 639) chk("to_639", char_to_irq, 1'b0);
         if (t == 640) chk("to_640", char_to_irq, TO_EN);
      end
      chk("to_early", early, 0);
      chk("to_hold", char_to_irq, TO_EN);
      read_one();
      chk("to_clr_pop", char_to_irq, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller that sequences the UART RX engine's 16-entry FIFO.
- Generates FIFO pops for CPU reads of the receive buffer (RBR), and drains the FIFO on a clear request.
- Maintains line-status information: data ready, sticky overrun, head-of-FIFO error flags and an error-in-FIFO count.
- Generates the three receive interrupt sources for the interrupt block: data available (trigger level), character timeout and line status.
- Sits between the RX engine/FIFO and the APB register file.

Parameters:
- FIFO_DEPTH, 16, entry count of the RX FIFO; count ports are $clog2(FIFO_DEPTH)+1 bits.
- TO_CHARS, 4, character-timeout length in character times.

Ports:
- PCLK  input  1  system clock
- PRESETn  input  1  reset, asynchronous assert, active-low
- enable  input  1  16x baud tick, one PCLK wide
- LCR  input  8  line control: [1:0] word length, [2] stop bits, [3] parity enable
- FCR_trig  input  2  RX trigger level select
- fifo_clear  input  1  one-cycle pulse: flush RX FIFO
- rbr_read  input  1  one-cycle pulse: CPU read of RBR
- lsr_read  input  1  one-cycle pulse: CPU read of LSR
- rx_fifo_out  input  11  FIFO head entry: [10] break, [9] parity error, [8] framing error, [7:0] data
- rx_fifo_count  input  5  FIFO occupancy
- rx_fifo_empty  input  1  FIFO empty
- push_rx_fifo  input  1  RX engine push strobe
- rx_overrun  input  1  RX engine overrun flag, valid in the push cycle
- push_err  input  1  OR of parity, framing and break flags, valid in the push cycle
- pop_rx_fifo  output  1  FIFO pop strobe
- rbr_data  output  8  receive buffer read data
- lsr  output  8  line status: [0] DR, [1] OE, [2] PE, [3] FE, [4] BI, [6:5] 0, [7] error-in-FIFO
- rx_avail_irq  output  1  occupancy at or above trigger level
- char_to_irq  output  1  character timeout
- rx_ls_irq  output  1  line-status interrupt
- ctrl_busy  output  1  high while in POP or DRAIN

Behaviour:
- Clocking and reset: all flops on posedge PCLK, asynchronously cleared by PRESETn low.
  - Reset values: state=IDLE, overrun sticky=0, err_cnt=0, timeout counter=0, char_to_irq=0.
  - All outputs are 0 in reset except rbr_data, which follows its combinational definition.
- FSM states:
  - IDLE: pop_rx_fifo=0.
    - fifo_clear=1 -> DRAIN. fifo_clear has priority over rbr_read in the same cycle.
    - Else rbr_read=1 and !rx_fifo_empty -> POP.
    - rbr_read while empty: no pop, rbr_data=0.
  - POP: pop_rx_fifo=1 for exactly one cycle, then -> IDLE. rbr_read arriving during POP is ignored; the APB two-cycle minimum access guarantees no read is lost.
  - DRAIN: pop_rx_fifo = !rx_fifo_empty (combinational). Exits to IDLE in the first cycle rx_fifo_empty=1. Pushes arriving during DRAIN are also drained.
  - Reset mid-POP or mid-DRAIN: returns immediately to IDLE with pop_rx_fifo=0.
- rbr_data: rx_fifo_out[7:0] masked to the word length (LCR[1:0]: 00->5, 01->6, 10->7, 11->8 bits); upper bits 0. Combinational, valid in the rbr_read cycle, i.e. one cycle before the pop edge.
- lsr bits:
  - DR = !rx_fifo_empty.
  - OE: set on push_rx_fifo & rx_overrun; cleared on the cycle after lsr_read. A set in the same cycle as lsr_read wins.
  - PE/FE/BI = rx_fifo_out[9]/[8]/[10] when !rx_fifo_empty, else 0.
  - bit7 = (err_cnt != 0).
- err_cnt (5 bits, saturating at FIFO_DEPTH):
  - +1 on push_rx_fifo & push_err.
  - -1 on pop_rx_fifo & |rx_fifo_out[10:8].
  - Both in the same cycle: unchanged.
  - Cleared in the cycle DRAIN is entered.
- rx_avail_irq = (rx_fifo_count >= trig). FCR_trig 00->1, 01->4, 10->8, 11->14.
- rx_ls_irq = OE | lsr[2] | lsr[3] | lsr[4].
- Character time: bits = 1 + (5 + LCR[1:0]) + LCR[3] + (LCR[2] ? 2 : 1). Threshold = TO_CHARS*16*bits; maximum 768 with the default TO_CHARS, so the counter is 10 bits.
- Timeout counter:
  - Increments on enable while !rx_fifo_empty and state==IDLE.
  - Cleared on push_rx_fifo, on pop_rx_fifo, or when the FIFO is empty.
  - Reaching the threshold sets char_to_irq and the counter holds.
  - char_to_irq clears on the next pop, push, or DRAIN.
- ctrl_busy = (state != IDLE).

Optional Feature:
- Macro UART_RX_CHAR_TIMEOUT_EN.
- Defined: timeout counter and char_to_irq are implemented as described above.
- Undefined: counter logic is omitted and char_to_irq is tied to 0; all other behaviour is unchanged.

Test Plan:
- Reset with FIFO count=3: all outputs 0 and state IDLE -> rbr_read pulse: rbr_data=head[7:0] that cycle, pop_rx_fifo=1 exactly the next cycle, ctrl_busy=1 for 1 cycle.
- LCR[1:0]=00, head=0xFF, rbr_read -> rbr_data=0x1F. Read with FIFO empty -> no pop, rbr_data=0.
- FCR_trig=10, push 7 entries -> rx_avail_irq=0; 8th push -> rx_avail_irq=1; one pop -> 0.
- Push with rx_overrun=1 -> lsr[1]=1 and rx_ls_irq=1. lsr_read -> lsr[1]=0 next cycle. Overrun push coincident with lsr_read -> lsr[1] stays 1.
- 2 error pushes plus 1 clean push -> lsr[7]=1. fifo_clear -> 3 consecutive pop cycles, then IDLE, lsr[7]=0, DR=0.
- Macro defined, LCR=0x03 (10-bit char), 1 entry, no activity -> char_to_irq rises after exactly 640 enable ticks; rbr_read -> char_to_irq=0 after the pop. Macro undefined -> char_to_irq never asserts.
